// File: rtl/hazard_sequencer.sv
// Pipeline hazard/stall sequencer: load-use stalls, redirect flushes, memory-wait freeze with timeout.
// Optional saturating performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_sequencer #(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned MEM_TIMEOUT    = 255,
    parameter int unsigned PERF_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      idex_memread,
    input  logic [REG_ADDR_WIDTH-1:0] idex_rd,
    input  logic [REG_ADDR_WIDTH-1:0] ifid_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] ifid_rs2,
    input  logic                      ifid_use_rs1,
    input  logic                      ifid_use_rs2,
    input  logic                      ex_pcsrc,
    input  logic                      mem_req,
    input  logic                      mem_ready,
    output logic                      pcwrite,
    output logic                      ifidwrite,
    output logic                      idexwrite,
    output logic                      exmemwrite,
    output logic                      clearcontrol,
    output logic                      ifid_flush,
    output logic                      idex_flush,
    output logic                      memwb_bubble,
    output logic                      mem_timeout,
    output logic [1:0]                state,
    output logic [PERF_WIDTH-1:0]     perf_stall,
    output logic [PERF_WIDTH-1:0]     perf_flush,
    output logic [PERF_WIDTH-1:0]     perf_memwait
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2,
        ILLEGAL  = 2'd3
    } state_t;

    localparam logic [15:0] TIMEOUT_C = 16'(MEM_TIMEOUT);

    state_t      state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        freeze_s, lu_hazard_s, hold_s, redirect_s, stall_s;

    assign freeze_s    = mem_req & ~mem_ready;
    assign lu_hazard_s = idex_memread & (idex_rd != {REG_ADDR_WIDTH{1'b0}}) &
                         ((ifid_use_rs1 & (ifid_rs1 == idex_rd)) |
                          (ifid_use_rs2 & (ifid_rs2 == idex_rd)));
    // A held redirect or hazard is simply re-evaluated once the freeze releases.
    assign hold_s      = (state_q == ERROR) | freeze_s;
    assign redirect_s  = ~hold_s & ex_pcsrc;
    assign stall_s     = ~hold_s & ~ex_pcsrc & lu_hazard_s;

    // Next-state and wait-counter logic; the timeout compare happens before the increment.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            RUN: begin
                wait_cnt_d = 16'd0;
                if (freeze_s) state_d = MEM_WAIT;
                else          state_d = RUN;
            end
            MEM_WAIT: begin
                if (mem_ready | ~mem_req) begin
                    state_d    = RUN;
                    wait_cnt_d = 16'd0;
                end else if (wait_cnt_q == TIMEOUT_C) begin
                    state_d = ERROR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = 16'd0;
            end
        endcase
    end

    // State and wait-counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RUN;
            wait_cnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Pipeline control decode; reset forces the free-running pattern immediately.
    always_comb begin
        pcwrite      = 1'b1;
        ifidwrite    = 1'b1;
        idexwrite    = 1'b1;
        exmemwrite   = 1'b1;
        clearcontrol = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        memwb_bubble = 1'b0;
        if (!rst) begin
            pcwrite = 1'b1;
        end else if (hold_s) begin
            pcwrite      = 1'b0;
            ifidwrite    = 1'b0;
            idexwrite    = 1'b0;
            exmemwrite   = 1'b0;
            memwb_bubble = 1'b1;
        end else if (redirect_s) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (stall_s) begin
            pcwrite      = 1'b0;
            ifidwrite    = 1'b0;
            clearcontrol = 1'b1;
            idex_flush   = 1'b1;
        end else begin
            pcwrite = 1'b1;
        end
    end

    assign mem_timeout = (state_q == ERROR);
    assign state       = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_WIDTH-1:0] perf_stall_q, perf_stall_d;
    logic [PERF_WIDTH-1:0] perf_flush_q, perf_flush_d;
    logic [PERF_WIDTH-1:0] perf_memwait_q, perf_memwait_d;
    logic                  memwait_inc_s;

    assign memwait_inc_s = freeze_s & (state_q != ERROR);

    // Saturating increments: each counter parks at all-ones.
    always_comb begin
        perf_stall_d   = perf_stall_q;
        perf_flush_d   = perf_flush_q;
        perf_memwait_d = perf_memwait_q;
        if (stall_s && (perf_stall_q != {PERF_WIDTH{1'b1}}))
            perf_stall_d = perf_stall_q + {{(PERF_WIDTH-1){1'b0}}, 1'b1};
        else
            perf_stall_d = perf_stall_q;
        if (redirect_s && (perf_flush_q != {PERF_WIDTH{1'b1}}))
            perf_flush_d = perf_flush_q + {{(PERF_WIDTH-1){1'b0}}, 1'b1};
        else
            perf_flush_d = perf_flush_q;
        if (memwait_inc_s && (perf_memwait_q != {PERF_WIDTH{1'b1}}))
            perf_memwait_d = perf_memwait_q + {{(PERF_WIDTH-1){1'b0}}, 1'b1};
        else
            perf_memwait_d = perf_memwait_q;
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_q   <= {PERF_WIDTH{1'b0}};
            perf_flush_q   <= {PERF_WIDTH{1'b0}};
            perf_memwait_q <= {PERF_WIDTH{1'b0}};
        end else begin
            perf_stall_q   <= perf_stall_d;
            perf_flush_q   <= perf_flush_d;
            perf_memwait_q <= perf_memwait_d;
        end
    end

    assign perf_stall   = perf_stall_q;
    assign perf_flush   = perf_flush_q;
    assign perf_memwait = perf_memwait_q;
`else
    assign perf_stall   = {PERF_WIDTH{1'b0}};
    assign perf_flush   = {PERF_WIDTH{1'b0}};
    assign perf_memwait = {PERF_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: directed scenarios then random traffic against a behavioural model.
module tb_hazard_sequencer;

    localparam int TO = 4;
    localparam int PW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          idex_memread, ifid_use_rs1, ifid_use_rs2, ex_pcsrc, mem_req, mem_ready;
    logic [4:0]    idex_rd, ifid_rs1, ifid_rs2;
    logic          pcwrite, ifidwrite, idexwrite, exmemwrite, clearcontrol;
    logic          ifid_flush, idex_flush, memwb_bubble, mem_timeout;
    logic [1:0]    state;
    logic [PW-1:0] perf_stall, perf_flush, perf_memwait;

    int errors = 0;
    int checks = 0;

    // Reference model: plain booleans and integers for the wait/error bookkeeping.
    bit      m_wait, m_err;
    int      m_cnt;
    longint  m_pstall, m_pflush, m_pmem;

    hazard_sequencer #(.REG_ADDR_WIDTH(5), .MEM_TIMEOUT(TO), .PERF_WIDTH(PW)) dut (
        .clk(clk), .rst(rst),
        .idex_memread(idex_memread), .idex_rd(idex_rd),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .ifid_use_rs1(ifid_use_rs1), .ifid_use_rs2(ifid_use_rs2),
        .ex_pcsrc(ex_pcsrc), .mem_req(mem_req), .mem_ready(mem_ready),
        .pcwrite(pcwrite), .ifidwrite(ifidwrite), .idexwrite(idexwrite), .exmemwrite(exmemwrite),
        .clearcontrol(clearcontrol), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .memwb_bubble(memwb_bubble), .mem_timeout(mem_timeout), .state(state),
        .perf_stall(perf_stall), .perf_flush(perf_flush), .perf_memwait(perf_memwait)
    );

    always #5 clk = ~clk;

    function automatic bit model_lu();
        return idex_memread && (idex_rd != 5'd0) &&
               ((ifid_use_rs1 && ifid_rs1 == idex_rd) || (ifid_use_rs2 && ifid_rs2 == idex_rd));
    endfunction

    function automatic bit model_frz();
        return mem_req && !mem_ready;
    endfunction

    // {pcwrite,ifidwrite,idexwrite,exmemwrite,clearcontrol,ifid_flush,idex_flush,memwb_bubble,mem_timeout}
    function automatic logic [8:0] exp_ctl();
        if (!rst)                    return 9'b1111_0000_0;
        if (m_err || model_frz())    return {8'b0000_0001, m_err};
        if (ex_pcsrc)                return 9'b1111_0110_0;
        if (model_lu())              return 9'b0011_1010_0;
        return 9'b1111_0000_0;
    endfunction

    function automatic logic [1:0] exp_state();
        if (!rst)   return 2'd0;
        if (m_err)  return 2'd2;
        if (m_wait) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [3*PW-1:0] exp_perf();
`ifdef HAZARD_PERF_CNT_EN
        return {PW'(m_pstall), PW'(m_pflush), PW'(m_pmem)};
`else
        return {(3*PW){1'b0}};
`endif
    endfunction

    task automatic model_reset();
        m_wait = 1'b0; m_err = 1'b0; m_cnt = 0;
        m_pstall = 0; m_pflush = 0; m_pmem = 0;
    endtask

    task automatic model_edge();
        bit frz;
        frz = model_frz();
        if (!rst) return;
        if (!m_err && !frz && ex_pcsrc)               m_pflush++;
        if (!m_err && !frz && !ex_pcsrc && model_lu()) m_pstall++;
        if (!m_err && frz)                            m_pmem++;
        if (m_err) begin
            m_err = 1'b1;
        end else if (!m_wait) begin
            if (frz) begin m_wait = 1'b1; m_cnt = 0; end
        end else if (mem_ready || !mem_req) begin
            m_wait = 1'b0;
        end else if (m_cnt == TO) begin
            m_err = 1'b1; m_wait = 1'b0;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic check(input string tag);
        logic [8:0] got;
        #1;
        got = {pcwrite, ifidwrite, idexwrite, exmemwrite, clearcontrol,
               ifid_flush, idex_flush, memwb_bubble, mem_timeout};
        checks++;
        assert (got === exp_ctl()) else begin
            errors++;
            $error("FAIL %s ctl got=%b exp=%b", tag, got, exp_ctl());
        end
        checks++;
        assert (state === exp_state()) else begin
            errors++;
            $error("FAIL %s state got=%0d exp=%0d", tag, state, exp_state());
        end
        checks++;
        assert ({perf_stall, perf_flush, perf_memwait} === exp_perf()) else begin
            errors++;
            $error("FAIL %s perf got=%0d/%0d/%0d", tag, perf_stall, perf_flush, perf_memwait);
        end
    endtask

    task automatic cycle(input string tag);
        check(tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic set_in(input bit mr, input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                          input bit u1, input bit u2, input bit pc, input bit mq, input bit rdy);
        idex_memread = mr; idex_rd = rd; ifid_rs1 = r1; ifid_rs2 = r2;
        ifid_use_rs1 = u1; ifid_use_rs2 = u2; ex_pcsrc = pc; mem_req = mq; mem_ready = rdy;
    endtask

    task automatic idle();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        check("reset");
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic const_chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        idle();
        model_reset();
        @(negedge clk);
        check("reset_hold");
        @(negedge clk);
        rst = 1'b1;
        cycle("idle");

        // Load-use on rs2, then the bubble (memread=0) must not re-stall.
        set_in(1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle("lu_rs2");
        set_in(1'b0, 5'd0, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle("lu_after");
        // False hazards: rd=x0, and rs1 match without use (lui).
        set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle("false_x0");
        set_in(1'b1, 5'd7, 5'd7, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle("false_lui");
        // Redirect and hazard together: redirect wins.
        set_in(1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle("redir_lu");
        idle();

        // Three-cycle memory wait with a pending redirect; redirect fires on the ready cycle.
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle("mw1");
        cycle("mw2");
        const_chk("mw_state", state, 2'd1);
        cycle("mw3");
        mem_ready = 1'b1;
        cycle("mw_ready");
        idle();
        cycle("mw_after");
        const_chk("mw_run", state, 2'd0);

        // Timeout: RUN edge plus five MEM_WAIT edges reaches ERROR.
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cycle("to_wait");
        const_chk("to_not_yet", state, 2'd1);
        cycle("to_edge5");
        const_chk("to_error", state, 2'd2);
        idle();
        cycle("err_held");
        cycle("err_held2");
        do_reset();
        cycle("post_err");

        // Asynchronous reset in the middle of a wait.
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle("pre_async1");
        cycle("pre_async2");
        #2;
        do_reset();
        idle();
        cycle("post_async");

        // Random traffic with a narrow register range so hazards are common.
        for (int i = 0; i < 400; i++) begin
            set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
                   1'($urandom_range(0, 3) != 0));
            if (m_err && $urandom_range(0, 3) == 0) do_reset();
            else cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
